mult_taint_seq: RTL and testbench

- Parametrised successor to the 4-bit shift-add taint-tracking multiplier.
- Iterative shift-add multiplier with per-transaction signed/unsigned mode and valid/ready handshakes on both sides.
- Bit-level taint shadow logic propagates through the datapath and control.
- Fixed, data-independent latency, so completion timing never depends on operand values. Sits between an operand-issuing unit and a result consumer in the taint-analysis testbench flow.

---
 rtl/mult_taint_seq_if.sv | 33 +++
 rtl/mult_taint_seq.sv | 163 ++++++++++++++++
 tb/tb_mult_taint_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mult_taint_seq_if.sv
// Operand/result handshake bundle for mult_taint_seq, with a bit-level taint
// shadow alongside every data and control signal.
interface mult_taint_seq_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_valid_t;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     multiplier_t;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplicand_t;
  logic                 signed_mode;
  logic                 signed_mode_t;
  logic                 out_valid;
  logic                 out_valid_t;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   product_t;

  // master: operand issuer plus result consumer
  modport master (
    output in_valid, in_valid_t, multiplier, multiplier_t,
           multiplicand, multiplicand_t, signed_mode, signed_mode_t, out_ready,
    input  in_ready, out_valid, out_valid_t, product, product_t
  );

  modport slave (
    input  in_valid, in_valid_t, multiplier, multiplier_t,
           multiplicand, multiplicand_t, signed_mode, signed_mode_t, out_ready,
    output in_ready, out_valid, out_valid_t, product, product_t
  );
endinterface

// File: rtl/mult_taint_seq.sv
// Iterative shift-add multiplier with constant latency and conservative
// bit-level taint tracking through datapath and handshake control.
module mult_taint_seq #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mult_taint_seq_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mr;
  logic [WIDTH-1:0]   r_md;
  logic [WIDTH-1:0]   r_mr_t;
  logic [WIDTH-1:0]   r_md_t;
  logic               r_neg;
  logic               r_signed;
  logic               r_smode_t;
  logic               r_ctl_t;
  logic [SW-1:0]      r_sum;
  logic [SW-1:0]      r_sum_t;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_out_valid_t;
  logic [PW-1:0]      r_product;
  logic [PW-1:0]      r_product_t;

  logic               w_eff_signed;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_bit;
  logic               w_bit_t;
  logic [SW-1:0]      w_addend;
  logic [SW-1:0]      w_addend_t;
  logic [SW-1:0]      w_or;
  logic [SW-1:0]      w_pref;
  logic [PW-1:0]      w_sum_lo;
  logic               w_whole_t;

  assign w_eff_signed = bus.signed_mode & SIGNED_EN;
  assign w_sign_a     = w_eff_signed & bus.multiplier[WIDTH-1];
  assign w_sign_b     = w_eff_signed & bus.multiplicand[WIDTH-1];
  // A WIDTH-bit two's-complement negate read as unsigned is the exact
  // magnitude, including 2^(WIDTH-1) for the most negative operand.
  assign w_mag_a      = w_sign_a ? -bus.multiplier   : bus.multiplier;
  assign w_mag_b      = w_sign_b ? -bus.multiplicand : bus.multiplicand;

  assign w_bit   = r_mr[r_cnt];
  assign w_bit_t = r_mr_t[r_cnt];

  always_comb begin
    w_addend   = '0;
    w_addend_t = '0;
    if (w_bit | w_bit_t) begin
      w_addend = SW'(r_md) << r_cnt;
    end
    if (w_bit_t) begin
      w_addend_t = SW'({(WIDTH+1){1'b1}}) << r_cnt;
    end else if (w_bit) begin
      w_addend_t = SW'(r_md_t) << r_cnt;
    end
  end

  // Any tainted bit may carry into every bit above it.
  assign w_or = r_sum_t | w_addend_t;
  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_pref
      assign w_pref[gi] = |w_or[gi:0];
    end
  endgenerate

  assign w_sum_lo  = r_sum[PW-1:0];
  assign w_whole_t = (r_signed & (r_mr_t[WIDTH-1] | r_md_t[WIDTH-1])) | r_smode_t;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mr          <= '0;
      r_md          <= '0;
      r_mr_t        <= '0;
      r_md_t        <= '0;
      r_neg         <= 1'b0;
      r_signed      <= 1'b0;
      r_smode_t     <= 1'b0;
      r_ctl_t       <= 1'b0;
      r_sum         <= '0;
      r_sum_t       <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_valid_t <= 1'b0;
      r_product     <= '0;
      r_product_t   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_mr       <= w_mag_a;
            r_md       <= w_mag_b;
            r_mr_t     <= bus.multiplier_t;
            r_md_t     <= bus.multiplicand_t;
            r_neg      <= w_sign_a ^ w_sign_b;
            r_signed   <= w_eff_signed;
            r_smode_t  <= bus.signed_mode_t;
            r_ctl_t    <= bus.in_valid_t;
            r_sum      <= '0;
            r_sum_t    <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum <= r_sum + w_addend;
          if (|w_addend_t) begin
            r_sum_t <= w_pref;
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_product   <= r_neg ? -w_sum_lo : w_sum_lo;
          r_product_t <= w_whole_t ? '1 : r_sum_t[PW-1:0];
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle is the output register stage; valid follows it.
          if (!r_out_valid) begin
            r_out_valid   <= 1'b1;
            r_out_valid_t <= r_ctl_t;
          end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
            r_out_valid_t <= 1'b0;
            r_in_ready    <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_valid_t = r_out_valid_t;
  assign bus.product     = r_product;
  assign bus.product_t   = r_product_t;

endmodule

// File: tb/tb_mult_taint_seq.sv
// Directed bench for mult_taint_seq (WIDTH=4): arithmetic/taint model plus
// literal pins, latency, back-pressure and asynchronous reset checks.
module tb_mult_taint_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int errors = 0;
  int checks = 0;

  logic       exp_pending = 1'b0;
  logic [7:0] exp_p  = '0;
  logic [7:0] exp_pt = '0;
  logic       exp_ovt = 1'b0;

  mult_taint_seq_if #(.WIDTH(4)) bus ();

  mult_taint_seq #(.WIDTH(4), .SIGNED_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected result from the arithmetic definition: magnitudes, a multiplier
  // where tainted bits count as ones, then sign; taint spreads from its
  // lowest tainted bit upward.
  function automatic void model(input logic [3:0] a, input logic [3:0] at,
                                input logic [3:0] b, input logic [3:0] bt,
                                input logic sm, input logic smt,
                                output logic [7:0] p, output logic [7:0] pt);
    int ma, mb, prod, low;
    logic sa, sb;
    logic [8:0] t, add;
    sa = sm & a[3];
    sb = sm & b[3];
    ma = sa ? 16 - int'(a) : int'(a);
    mb = sb ? 16 - int'(b) : int'(b);
    prod = ((ma | int'(at)) & 15) * mb;
    if (sa ^ sb) prod = -prod;
    p = 8'(prod);
    t = '0;
    for (int i = 0; i < 4; i++) begin
      if (at[i])      add = 9'h01F << i;
      else if (ma[i]) add = 9'(bt) << i;
      else            add = '0;
      if (add != 0) begin
        t = t | add;
        low = 0;
        for (int k = 8; k >= 0; k--) if (t[k]) low = k;
        t = 9'h1FF << low;
      end
    end
    pt = ((sm && (at[3] || bt[3])) || smt) ? 8'hFF : t[7:0];
  endfunction

  // Advance one cycle and compare every output-valid cycle against the model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (bus.out_valid) begin
      chk("ov_expected", exp_pending, 1);
      chk("product", bus.product, exp_p);
      chk("product_t", bus.product_t, exp_pt);
      chk("out_valid_t", bus.out_valid_t, exp_ovt);
      chk("in_ready_busy", bus.in_ready, 0);
    end
  endtask

  task automatic run_txn(input logic [3:0] a, input logic [3:0] at,
                         input logic [3:0] b, input logic [3:0] bt,
                         input logic sm, input logic smt, input logic ivt,
                         input int hold, input bit pin,
                         input logic [7:0] lit_p, input logic [7:0] lit_pt);
    int  n;
    bit  seen;
    logic [7:0] mp, mpt;
    model(a, at, b, bt, sm, smt, mp, mpt);
    exp_p   = mp;
    exp_pt  = mpt;
    exp_ovt = ivt;
    bus.multiplier     = a;
    bus.multiplier_t   = at;
    bus.multiplicand   = b;
    bus.multiplicand_t = bt;
    bus.signed_mode    = sm;
    bus.signed_mode_t  = smt;
    bus.in_valid_t     = ivt;
    bus.in_valid       = 1'b1;
    chk("in_ready_idle", bus.in_ready, 1);
    exp_pending = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_valid_t = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.out_valid) seen = 1;
    end
    chk("latency", n, 6);
    if (seen) begin
      if (pin) begin
        chk("lit_product", bus.product, lit_p);
        chk("lit_product_t", bus.product_t, lit_pt);
      end
      for (int h = 0; h < hold; h++) begin
        bus.in_valid     = h[0];
        bus.multiplier   = 4'h1;
        bus.multiplicand = 4'h1;
        tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      exp_pending   = 1'b0;
      chk("out_valid_drop", bus.out_valid, 0);
      chk("in_ready_back", bus.in_ready, 1);
    end
    $display("txn a=%h at=%h b=%h bt=%h sm=%0d smt=%0d ivt=%0d -> product=%h product_t=%h (model %h/%h) latency=%0d",
             a, at, b, bt, sm, smt, ivt, bus.product, bus.product_t, mp, mpt, n);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_valid_t = 0; bus.out_ready = 0;
    bus.multiplier = 0; bus.multiplier_t = 0;
    bus.multiplicand = 0; bus.multiplicand_t = 0;
    bus.signed_mode = 0; bus.signed_mode_t = 0;

    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_valid_t", bus.out_valid_t, 0);
    chk("rst_product", bus.product, 0);
    chk("rst_product_t", bus.product_t, 0);
    @(negedge clk);
    rst = 1'b0;

    //        a     at    b     bt    sm smt ivt hold pin  lit_p  lit_pt
    run_txn(4'd13, 4'h0, 4'd11, 4'h0, 0, 0, 0, 0, 1, 8'h8F, 8'h00);
    run_txn(4'hD,  4'h0, 4'd5,  4'h0, 1, 0, 0, 0, 1, 8'hF1, 8'h00);
    run_txn(4'h8,  4'h0, 4'h8,  4'h0, 1, 0, 0, 0, 1, 8'h40, 8'h00);
    run_txn(4'h8,  4'h0, 4'h7,  4'h0, 1, 0, 0, 0, 1, 8'hC8, 8'h00);
    run_txn(4'd2,  4'h0, 4'd1,  4'h1, 0, 0, 0, 0, 1, 8'h02, 8'hFE);
    run_txn(4'd0,  4'h8, 4'd0,  4'h0, 0, 0, 0, 0, 1, 8'h00, 8'hF8);
    run_txn(4'd3,  4'h0, 4'd2,  4'h8, 1, 0, 0, 0, 1, 8'h06, 8'hFF);
    run_txn(4'd3,  4'h0, 4'hE,  4'h0, 1, 1, 0, 0, 1, 8'hFA, 8'hFF);
    run_txn(4'd5,  4'h0, 4'd6,  4'h0, 0, 0, 1, 0, 1, 8'h1E, 8'h00);
    run_txn(4'd7,  4'h0, 4'd9,  4'h0, 0, 0, 0, 10, 1, 8'h3F, 8'h00);
    run_txn(4'd0,  4'h2, 4'd3,  4'h0, 0, 0, 0, 0, 1, 8'h06, 8'hFE);
    run_txn(4'hB,  4'h1, 4'h9,  4'h2, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    run_txn(4'd5,  4'h0, 4'hA,  4'h4, 0, 0, 0, 1, 0, 8'h00, 8'h00);

    // Asynchronous reset while RUN is at counter 2.
    bus.multiplier = 4'd9; bus.multiplicand = 4'd9;
    bus.signed_mode = 0; bus.multiplier_t = 0; bus.multiplicand_t = 0;
    bus.in_valid = 1'b1;
    exp_pending = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("run_in_ready", bus.in_ready, 0);
    #2 rst = 1'b1;
    exp_pending = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_product", bus.product, 0);
    chk("arst_product_t", bus.product_t, 0);
    chk("arst_out_valid_t", bus.out_valid_t, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    run_txn(4'hF, 4'h0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 8'hE1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
